// File: rtl/shifter_pkg.sv
// Shared constants for the sequential shift unit: shift-mode codes and FSM state encoding.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational shift by k (0..STEP) positions in one of four modes.
// Built as a log2(STEP)+1 stage mux network, one power-of-two stage per bit of k.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_k,
  input  logic [1:0]       i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_stage [KW+1];

  assign w_stage[0] = i_data;

  for (genvar gi = 0; gi < KW; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_shifted;

    // Double-width views keep a shift by the full WIDTH well defined.
    assign w_sra = WIDTH'({{WIDTH{i_sign}}, w_stage[gi]} >> SH);
    assign w_rot = WIDTH'({w_stage[gi], w_stage[gi]} >> (WIDTH - SH));

    always_comb begin
      w_shifted = w_stage[gi] << SH;
      case (i_mode)
        MODE_SLL:  w_shifted = w_stage[gi] << SH;
        MODE_SRL:  w_shifted = w_stage[gi] >> SH;
        MODE_SRA:  w_shifted = w_sra;
        MODE_ROTL: w_shifted = w_rot;
        default:   w_shifted = w_stage[gi] << SH;
      endcase
    end

    assign w_stage[gi+1] = i_k[gi] ? w_shifted : w_stage[gi];
  end

  assign o_data = w_stage[KW];

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts a command, shifts up to STEP positions per cycle,
// then presents the registered result until the consumer takes it.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STEP     = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               busy
);

  localparam int KW = $clog2(STEP) + 1;

  state_t             r_state, r_state_next;
  logic [WIDTH-1:0]   r_data, r_data_next;
  logic [SHAMT_W-1:0] r_remaining, r_remaining_next;
  logic [1:0]         r_mode, r_mode_next;
  logic               r_sign, r_sign_next;
  logic [WIDTH-1:0]   r_result, r_result_next;

  logic [KW-1:0]      w_k;
  logic [WIDTH-1:0]   w_shifted;

  // k = min(STEP, remaining); compared at 32 bits since STEP may equal WIDTH.
  always_comb begin
    if (32'(r_remaining) >= STEP) w_k = KW'(STEP);
    else                          w_k = KW'(r_remaining);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (r_data),
    .i_k    (w_k),
    .i_mode (r_mode),
    .i_sign (r_sign),
    .o_data (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_remaining <= '0;
      r_mode      <= MODE_SLL;
      r_sign      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= r_state_next;
      r_data      <= r_data_next;
      r_remaining <= r_remaining_next;
      r_mode      <= r_mode_next;
      r_sign      <= r_sign_next;
      r_result    <= r_result_next;
    end
  end

  always_comb begin
    r_state_next     = r_state;
    r_data_next      = r_data;
    r_remaining_next = r_remaining;
    r_mode_next      = r_mode;
    r_sign_next      = r_sign;
    r_result_next    = r_result;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          r_data_next      = in_a;
          r_mode_next      = in_mode;
          r_sign_next      = in_a[WIDTH-1];
          r_remaining_next = in_shamt;
          if (in_shamt == '0) begin
            r_state_next  = ST_DONE;
            r_result_next = in_a;
          end else begin
            r_state_next  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        r_data_next      = w_shifted;
        r_remaining_next = r_remaining - SHAMT_W'(w_k);
        if (r_remaining_next == '0) begin
          r_state_next  = ST_DONE;
          r_result_next = w_shifted;
        end
      end
      ST_DONE: begin
        if (out_ready) r_state_next = ST_IDLE;
      end
      default: r_state_next = ST_IDLE;
    endcase
  end

  assign in_ready   = (r_state == ST_IDLE) && !reset;
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign out_result = r_result;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: five instances (STEP 1,2,4,8,32) share operand inputs,
// each with its own in_valid; results and latencies are checked against hand-computed values.
module tb_seq_shifter;
  import shifter_pkg::*;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        in_valid   [N];
  logic        in_ready   [N];
  logic        out_valid  [N];
  logic [31:0] out_result [N];
  logic        busy       [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : (gi == 3) ? 8 : 32;
    seq_shifter #(.WIDTH(32), .STEP(S)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_mode    (in_mode),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready),
      .out_result (out_result[gi]),
      .busy       (busy[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one command between edges; lat counts edges from the one before acceptance.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [4:0] sh,
                        input logic [1:0] md, input logic [31:0] exp_res,
                        input int exp_lat, input string tag);
    int lat;
    in_a = a; in_shamt = sh; in_mode = md; in_valid[idx] = 1'b1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(busy[idx]), 32'd1);
    while (!out_valid[idx] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, out_result[idx], exp_res);
    @(negedge clk);
    check({tag, "_drop"}, {30'd0, out_valid[idx], in_ready[idx]}, 32'd1);
    $display("[TB] %s: step_idx=%0d a=%h sh=%0d mode=%0d result=%h lat=%0d",
             tag, idx, a, sh, md, out_result[idx], lat);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    in_a = '0; in_shamt = '0; in_mode = MODE_SLL;
    for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(in_ready[i]), 32'd0);
      check($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_res%0d", i), out_result[i], 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel_ready0", 32'(in_ready[0]), 32'd1);

    run_op(0, 32'h0000_0001, 5'd2,  MODE_SLL,  32'h0000_0004, 3,  "s1_sll2");
    run_op(0, 32'h7FFF_FFFF, 5'd3,  MODE_SRA,  32'h0FFF_FFFF, 4,  "s1_sra3");
    run_op(1, 32'h8000_0000, 5'd5,  MODE_SRL,  32'h0400_0000, 4,  "s2_srl5");
    run_op(1, 32'h0000_0001, 5'd31, MODE_ROTL, 32'h8000_0000, 17, "s2_rot31");
    run_op(2, 32'h8000_0000, 5'd31, MODE_SRA,  32'hFFFF_FFFF, 9,  "s4_sra31");
    run_op(2, 32'h8000_0000, 5'd31, MODE_SRL,  32'h0000_0001, 9,  "s4_srl31");
    run_op(2, 32'hF000_0000, 5'd6,  MODE_ROTL, 32'h0000_003C, 3,  "s4_rot6");
    run_op(2, 32'h0000_ABCD, 5'd16, MODE_SLL,  32'hABCD_0000, 5,  "s4_sll16");
    run_op(3, 32'h8000_0001, 5'd1,  MODE_ROTL, 32'h0000_0003, 2,  "s8_rot1");
    run_op(3, 32'h1234_5678, 5'd12, MODE_ROTL, 32'h4567_8123, 3,  "s8_rot12");
    run_op(3, 32'hFFFF_FFFF, 5'd17, MODE_SRL,  32'h0000_7FFF, 4,  "s8_srl17");
    run_op(3, 32'h8000_0000, 5'd8,  MODE_SRA,  32'hFF80_0000, 2,  "s8_sra8");
    run_op(4, 32'h8000_0000, 5'd4,  MODE_SRA,  32'hF800_0000, 2,  "s32_sra4");
    run_op(4, 32'h1234_5678, 5'd31, MODE_ROTL, 32'h091A_2B3C, 2,  "s32_rot31");
    run_op(4, 32'h4000_0000, 5'd30, MODE_SRA,  32'h0000_0001, 2,  "s32_sra30");

    // Zero shift with back-pressure; a stray in_valid while DONE must be ignored.
    out_ready = 1'b0;
    in_a = 32'hDEAD_BEEF; in_shamt = 5'd0; in_mode = MODE_SLL; in_valid[4] = 1'b1;
    @(negedge clk);
    in_valid[4] = 1'b0;
    check("hold_valid0", 32'(out_valid[4]), 32'd1);
    check("hold_res0", out_result[4], 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      in_a = 32'h1111_1111; in_valid[4] = (c == 2);
      @(negedge clk);
      check($sformatf("hold_valid_c%0d", c), 32'(out_valid[4]), 32'd1);
      check($sformatf("hold_res_c%0d", c), out_result[4], 32'hDEAD_BEEF);
      check($sformatf("hold_ready_c%0d", c), 32'(in_ready[4]), 32'd0);
    end
    in_valid[4] = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("hold_release", {30'd0, out_valid[4], in_ready[4]}, 32'd1);
    check("hold_keep", out_result[4], 32'hDEAD_BEEF);
    @(negedge clk);
    check("hold_no_phantom", 32'(busy[4]), 32'd0);
    $display("[TB] hold: result=%h held under out_ready=0", out_result[4]);

    // Reset in the middle of a long STEP=1 shift discards the operation.
    in_a = 32'h0000_0001; in_shamt = 5'd20; in_mode = MODE_SLL; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy[0]), 32'd1);
    check("mid_valid", 32'(out_valid[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_busy", 32'(busy[0]), 32'd0);
    check("rst2_valid", 32'(out_valid[0]), 32'd0);
    check("rst2_res", out_result[0], 32'd0);
    check("rst2_ready_low", 32'(in_ready[0]), 32'd0);
    check("rst2_res_s8", out_result[3], 32'd0);
    reset = 1'b0;
    #1;
    check("rst2_ready", 32'(in_ready[0]), 32'd1);
    $display("[TB] reset mid-shift: busy=%0d result=%h", busy[0], out_result[0]);
    run_op(0, 32'h0000_0003, 5'd1, MODE_SRL, 32'h0000_0001, 2, "s1_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
